// File: rtl/easyaxi_mst_rd_arb_pkg.sv
// Shared AXI read-channel encodings and field widths for the easyaxi read arbiter.
package easyaxi_mst_rd_arb_pkg;
   localparam int LEN_W   = 8;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 2;

   typedef enum logic [BURST_W-1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_e;

   typedef enum logic [RESP_W-1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_e;
endpackage

// File: rtl/easyaxi_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module easyaxi_rr_grant #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = IDX_W'(i);
            end
         end
      end
   end
endmodule

// File: rtl/easyaxi_mst_rd_arb.sv
// Shares one AXI read master port among NUM_REQ requesters; requester index rides in the top ARID bits.
module easyaxi_mst_rd_arb
   import easyaxi_mst_rd_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int OST_MAX = 4
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]    req_len,
   input  logic [NUM_REQ*SIZE_W-1:0]   req_size,
   input  logic [NUM_REQ*BURST_W-1:0]  req_burst,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [DATA_W-1:0]           rsp_data,
   output logic [RESP_W-1:0]           rsp_resp,
   output logic                        rsp_last,
   output logic                        axi_arvalid,
   input  logic                        axi_arready,
   output logic [ID_W-1:0]             axi_arid,
   output logic [ADDR_W-1:0]           axi_araddr,
   output logic [LEN_W-1:0]            axi_arlen,
   output logic [SIZE_W-1:0]           axi_arsize,
   output logic [BURST_W-1:0]          axi_arburst,
   input  logic                        axi_rvalid,
   output logic                        axi_rready,
   input  logic [ID_W-1:0]             axi_rid,
   input  logic [DATA_W-1:0]           axi_rdata,
   input  logic [RESP_W-1:0]           axi_rresp,
   input  logic                        axi_rlast,
   output logic                        idle,
   output logic                        err_rid
);
   localparam int OST_W = $clog2(OST_MAX + 1);

   logic [NUM_REQ-1:0][OST_W-1:0] ost_cnt;
   logic [NUM_REQ-1:0]            eligible, gnt, ost_zero, dec;
   logic [IDX_W-1:0]              win_idx, rr_ptr, r_idx;
   logic                          load, grant, r_in_range, r_own_zero, r_hs;

   always_comb begin
      eligible = '0;
      ost_zero = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] & (ost_cnt[i] != OST_W'(OST_MAX));
         ost_zero[i] = (ost_cnt[i] == '0);
      end
   end

   easyaxi_rr_grant #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_grant (
      .req (eligible),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (win_idx)
   );

   // AR stage may take a new request whenever it is empty or draining this cycle
   assign load      = ~axi_arvalid | axi_arready;
   assign grant     = load & (|eligible);
   assign req_ready = grant ? gnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         axi_arvalid <= 1'b0;
         axi_arid    <= '0;
         axi_araddr  <= '0;
         axi_arlen   <= '0;
         axi_arsize  <= '0;
         axi_arburst <= '0;
         rr_ptr      <= '0;
      end else if (grant) begin
         axi_arvalid <= 1'b1;
         axi_arid    <= ID_W'(win_idx) << (ID_W - IDX_W);
         axi_araddr  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
         axi_arlen   <= req_len[int'(win_idx)*LEN_W +: LEN_W];
         axi_arsize  <= req_size[int'(win_idx)*SIZE_W +: SIZE_W];
         axi_arburst <= req_burst[int'(win_idx)*BURST_W +: BURST_W];
         rr_ptr      <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (axi_arready) begin
         axi_arvalid <= 1'b0;
      end
   end

   assign r_idx      = axi_rid[ID_W-1 -: IDX_W];
   assign r_in_range = int'(r_idx) < NUM_REQ;

   // Beats for a nonexistent requester are sunk so the R channel never stalls
   always_comb begin
      rsp_valid  = '0;
      dec        = '0;
      axi_rready = 1'b1;
      r_own_zero = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_in_range && r_idx == IDX_W'(i)) begin
            rsp_valid[i] = axi_rvalid;
            axi_rready   = rsp_ready[i];
            r_own_zero   = ost_zero[i];
            dec[i]       = axi_rvalid & rsp_ready[i] & axi_rlast & ~ost_zero[i];
         end
      end
   end

   assign r_hs     = axi_rvalid & axi_rready;
   assign rsp_data = axi_rdata;
   assign rsp_resp = axi_rresp;
   assign rsp_last = axi_rlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ost_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] & ~dec[i])      ost_cnt[i] <= ost_cnt[i] + 1'b1;
            else if (dec[i] & ~req_ready[i]) ost_cnt[i] <= ost_cnt[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       err_rid <= 1'b0;
      else if (r_hs & (~r_in_range | r_own_zero))       err_rid <= 1'b1;
   end

   assign idle = ~axi_arvalid & ~(|ost_cnt);
endmodule

// File: tb/tb_easyaxi_mst_rd_arb.sv
// Randomised scoreboard bench for easyaxi_mst_rd_arb, plus a NUM_REQ=3 instance for out-of-range RID.
module tb_easyaxi_mst_rd_arb;
   localparam int N  = 4;
   localparam int OM = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*32-1:0] req_addr;
   logic [N*8-1:0]  req_len;
   logic [N*3-1:0]  req_size;
   logic [N*2-1:0]  req_burst;
   logic [31:0]     rsp_data, axi_araddr, axi_rdata;
   logic [1:0]      rsp_resp, axi_arburst, axi_rresp;
   logic            rsp_last, axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast, idle, err_rid;
   logic [3:0]      axi_arid, axi_rid;
   logic [7:0]      axi_arlen;
   logic [2:0]      axi_arsize;

   easyaxi_mst_rd_arb #(.NUM_REQ(N), .IDX_W(2), .ID_W(4), .ADDR_W(32), .DATA_W(32), .OST_MAX(OM)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_len(req_len), .req_size(req_size), .req_burst(req_burst), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid), .axi_araddr(axi_araddr),
      .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready), .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rlast(axi_rlast), .idle(idle), .err_rid(err_rid));

   // three-requester instance, used only to hit an unused requester index
   logic [2:0]  t_req_valid, t_req_ready, t_rsp_valid, t_rsp_ready;
   logic [95:0] t_req_addr;
   logic [23:0] t_req_len;
   logic [8:0]  t_req_size;
   logic [5:0]  t_req_burst;
   logic [31:0] t_rsp_data, t_araddr;
   logic [1:0]  t_rsp_resp, t_arburst;
   logic        t_rsp_last, t_arvalid, t_rvalid, t_rready, t_idle, t_err;
   logic [3:0]  t_arid, t_rid;
   logic [7:0]  t_arlen;
   logic [2:0]  t_arsize;

   easyaxi_mst_rd_arb #(.NUM_REQ(3), .IDX_W(2), .ID_W(4), .ADDR_W(32), .DATA_W(32), .OST_MAX(OM)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_addr(t_req_addr),
      .req_len(t_req_len), .req_size(t_req_size), .req_burst(t_req_burst), .rsp_valid(t_rsp_valid),
      .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_resp(t_rsp_resp), .rsp_last(t_rsp_last),
      .axi_arvalid(t_arvalid), .axi_arready(1'b1), .axi_arid(t_arid), .axi_araddr(t_araddr),
      .axi_arlen(t_arlen), .axi_arsize(t_arsize), .axi_arburst(t_arburst), .axi_rvalid(t_rvalid),
      .axi_rready(t_rready), .axi_rid(t_rid), .axi_rdata(32'h5a5a_0003), .axi_rresp(2'd0),
      .axi_rlast(1'b1), .idle(t_idle), .err_rid(t_err));

   typedef struct {logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} ar_t;
   typedef struct {int idx; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
   typedef struct {logic [3:0] id; int left;} bst_t;

   ar_t  ar_q[$];
   r_t   r_q[$];
   bst_t bq[$];

   int n_chk = 0, n_err = 0;
   int ost[N];
   int ptr;
   bit m_arv, m_err, pres, stray;
   int pk;
   int p_req, p_ardy, p_r, p_rr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit all_zero();
      for (int i = 0; i < N; i++) if (ost[i] != 0) return 1'b0;
      return 1'b1;
   endfunction

   // one cycle: drive at negedge, check combinational outputs and advance the model just before posedge
   task automatic step();
      int w, ridx, j;
      logic [N-1:0] exp_rr;
      bit exp_rrdy;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = ($urandom_range(99) < p_req);
         req_addr[i*32 +: 32]  = $urandom;
         req_len[i*8 +: 8]     = 8'($urandom_range(7));
         req_size[i*3 +: 3]    = 3'($urandom_range(2));
         req_burst[i*2 +: 2]   = 2'($urandom_range(2));
         rsp_ready[i]          = ($urandom_range(99) < p_rr);
      end
      axi_arready = ($urandom_range(99) < p_ardy);
      if (stray) begin
         pres = 1'b1; pk = -1;
         axi_rid = 4'b1000; axi_rdata = $urandom; axi_rresp = 2'd2; axi_rlast = 1'b1;
         rsp_ready[2] = 1'b1;
      end else if (!pres && bq.size() > 0 && $urandom_range(99) < p_r) begin
         j = $urandom_range(bq.size() - 1);
         pk = j;
         for (int k = j; k >= 0; k--) if (bq[k].id == bq[j].id) pk = k;
         pres = 1'b1;
         axi_rid = bq[pk].id; axi_rdata = $urandom; axi_rresp = 2'($urandom_range(3));
         axi_rlast = (bq[pk].left == 1);
      end
      axi_rvalid = pres;
      #2;
      w = -1;
      if (!m_arv || axi_arready)
         for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(ptr + k) % N] && ost[(ptr + k) % N] < OM) w = (ptr + k) % N;
      exp_rr = (w >= 0) ? N'(1 << w) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      chk("arvalid", 64'(axi_arvalid), 64'(m_arv));
      chk("idle", 64'(idle), 64'(!m_arv && all_zero()));
      chk("err_rid", 64'(err_rid), 64'(m_err));
      ridx = int'(axi_rid[3:2]);
      exp_rrdy = rsp_ready[ridx];
      chk("rready", 64'(axi_rready), 64'(exp_rrdy));
      chk("rsp_valid", 64'(rsp_valid), axi_rvalid ? 64'(1 << ridx) : 64'(0));
      if (axi_rvalid && exp_rrdy) begin
         r_q.push_back('{ridx, axi_rdata, axi_rresp, axi_rlast});
         if (ost[ridx] == 0) m_err = 1'b1;
         else if (axi_rlast) ost[ridx]--;
         if (pk >= 0) begin
            bq[pk].left--;
            if (bq[pk].left == 0) bq.delete(pk);
         end
         pres = 1'b0;
      end
      if (axi_arvalid && axi_arready) bq.push_back('{axi_arid, int'(axi_arlen) + 1});
      if (w >= 0) begin
         ost[w]++;
         ar_q.push_back('{4'(w << 2), req_addr[w*32 +: 32], req_len[w*8 +: 8], req_size[w*3 +: 3], req_burst[w*2 +: 2]});
         ptr = (w + 1) % N;
         m_arv = 1'b1;
      end else if (axi_arready) begin
         m_arv = 1'b0;
      end
   endtask

   task automatic run(input int cyc, input int a, input int b, input int c, input int d);
      p_req = a; p_ardy = b; p_r = c; p_rr = d;
      repeat (cyc) step();
   endtask

   // monitor: pops expectations whenever the DUT completes an AR or a response beat
   always @(negedge clk) begin
      ar_t e;
      r_t  r;
      #3;
      if (rst_n) begin
         if (axi_arvalid && axi_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 64'(axi_arid), 64'hffff);
            else begin
               e = ar_q.pop_front();
               chk("arid", 64'(axi_arid), 64'(e.id));
               chk("araddr", 64'(axi_araddr), 64'(e.addr));
               chk("arlen", 64'(axi_arlen), 64'(e.len));
               chk("arsize", 64'(axi_arsize), 64'(e.size));
               chk("arburst", 64'(axi_arburst), 64'(e.burst));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (r_q.size() == 0) chk("rsp_unexpected", 64'(i), 64'hffff);
               else begin
                  r = r_q.pop_front();
                  chk("rsp_owner", 64'(i), 64'(r.idx));
                  chk("rsp_data", 64'(rsp_data), 64'(r.data));
                  chk("rsp_resp", 64'(rsp_resp), 64'(r.resp));
                  chk("rsp_last", 64'(rsp_last), 64'(r.last));
               end
            end
         end
      end
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      req_valid = '0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0; rsp_ready = '0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
      t_req_valid = '0; t_req_addr = '0; t_req_len = '0; t_req_size = '0; t_req_burst = '0;
      t_rsp_ready = '0; t_rvalid = 1'b0; t_rid = '0;
      for (int i = 0; i < N; i++) ost[i] = 0;
      ptr = 0; m_arv = 1'b0; m_err = 1'b0; pres = 1'b0; stray = 1'b0; pk = -1;
      repeat (2) @(negedge clk);
      #2;
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
      chk("rst_arid", 64'(axi_arid), 64'd0);
      chk("rst_araddr", 64'(axi_araddr), 64'd0);
      chk("rst_err", 64'(err_rid), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rready", 64'(axi_rready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(20, 100, 100, 0, 100);   // strict RR order, then saturation at OST_MAX
      run(400, 50, 60, 60, 70);
      run(200, 80, 10, 50, 50);    // long AR stalls
      run(300, 30, 100, 70, 30);

      p_req = 0; p_ardy = 100; p_r = 100; p_rr = 100;
      guard = 0;
      while (!(idle && !m_arv && all_zero() && bq.size() == 0 && !pres) && guard < 2000) begin
         step();
         guard++;
      end
      chk("drain_done", 64'(guard < 2000), 64'd1);

      stray = 1'b1; step(); stray = 1'b0;
      p_r = 0;
      repeat (3) step();
      chk("stray_err_sticky", 64'(err_rid), 64'd1);
      chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
      chk("r_q_empty", 64'(r_q.size()), 64'd0);

      @(negedge clk);
      t_rsp_ready = '0; t_rid = 4'b1100; t_rvalid = 1'b1;
      #2;
      chk("oor_rready", 64'(t_rready), 64'd1);
      chk("oor_rsp_valid", 64'(t_rsp_valid), 64'd0);
      chk("oor_err_before", 64'(t_err), 64'd0);
      @(negedge clk);
      t_rvalid = 1'b0; t_rid = 4'b0100;
      #2;
      chk("oor_err_set", 64'(t_err), 64'd1);
      repeat (3) @(negedge clk);
      #2;
      chk("oor_err_sticky", 64'(t_err), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("oor_err_reset", 64'(t_err), 64'd0);
      chk("err_reset", 64'(err_rid), 64'd0);
      chk("idle_reset", 64'(idle), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
